fp_addsub_norm_round_stage: RTL and testbench

//  Pipelined stage 3 of the FP add/sub datapath; consumes Adder1/Adder2/ExponentBase from stage 2.

---
 rtl/fp_addsub_norm_round_stage.sv | 145 ++++++++++++++
 tb/tb_fp_addsub_norm_round_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_norm_round_stage.sv
// Final stage of the single-precision add/sub datapath: mantissa add, normalise,
// round-to-nearest-even and IEEE-754 pack, as a two-register stallable pipeline.
module fp_addsub_norm_round_stage #(
  parameter int FractionSize = 23,
  parameter int MantissaSize = FractionSize + 1,
  parameter int RoundingSize = MantissaSize + 3,
  parameter int ExponentSize = 8,
  parameter int DataSize     = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RoundingSize-1:0] Adder1,
  input  logic [RoundingSize-1:0] Adder2,
  input  logic [ExponentSize-1:0] ExponentBase,
  input  logic                    EffOperation,
  input  logic                    ResultSign,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [DataSize-1:0]     Result,
  output logic                    Overflow,
  output logic                    Underflow
);

  localparam int LzcW   = $clog2(RoundingSize + 1);
  localparam int ExpW   = ExponentSize + 2;
  localparam int MrW    = MantissaSize + 1;
  localparam int ExpMax = (1 << ExponentSize) - 1;

  // Leading-zero count; an all-zero input reports the full width.
  function automatic logic [LzcW-1:0] lzc(input logic [RoundingSize-1:0] v);
    logic [LzcW-1:0] n;
    logic            found;
    n     = LzcW'(RoundingSize);
    found = 1'b0;
    for (int i = RoundingSize - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LzcW'(RoundingSize - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest-even on {M,G,R,S}; the MSB of the return is the carry out of M.
  function automatic logic [MrW-1:0] round_rne(input logic [RoundingSize-1:0] v);
    logic up;
    up = v[2] & (v[1] | v[0] | v[3]);
    return {1'b0, v[RoundingSize-1:3]} + MrW'(up);
  endfunction

  logic                           advance;
  logic                           vld_p1;
  logic [RoundingSize:0]          sum_p1;
  logic [ExponentSize-1:0]        exp_p1;
  logic                           sign_p1;
  logic                           sub_p1;

  logic                           vld_p2;
  logic [DataSize-1:0]            result_p2;
  logic                           ovf_p2;
  logic                           unf_p2;

  logic                           carry;
  logic                           is_zero;
  logic [LzcW-1:0]                shamt;
  logic [RoundingSize-1:0]        norm;
  logic signed [ExpW-1:0]         exp_n;
  logic signed [ExpW-1:0]         exp_r;
  logic [MrW-1:0]                 mr;
  logic [FractionSize-1:0]        frac;
  logic [DataSize-1:0]            res;
  logic                           ovf;
  logic                           unf;

  assign advance   = OutReady | ~vld_p2;
  assign InReady   = advance;
  assign OutValid  = vld_p2;
  assign Result    = result_p2;
  assign Overflow  = ovf_p2;
  assign Underflow = unf_p2;

  // ---- SUM stage: carry-in doubles as the +1 of the two's-complement subtract
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      exp_p1  <= '0;
      sign_p1 <= 1'b0;
      sub_p1  <= 1'b0;
    end else if (advance) begin
      vld_p1  <= InValid;
      sum_p1  <= {1'b0, Adder1} + {1'b0, Adder2} + {{RoundingSize{1'b0}}, EffOperation};
      exp_p1  <= ExponentBase;
      sign_p1 <= ResultSign;
      sub_p1  <= EffOperation;
    end
  end

  always_comb begin
    carry   = ~sub_p1 & sum_p1[RoundingSize];
    shamt   = lzc(sum_p1[RoundingSize-1:0]);
    is_zero = ~carry & (sum_p1[RoundingSize-1:0] == '0);
    if (carry) begin
      norm  = {sum_p1[RoundingSize:2], |sum_p1[1:0]};
      exp_n = $signed({2'b00, exp_p1}) + 10'sd1;
    end else begin
      norm  = sum_p1[RoundingSize-1:0] << shamt;
      exp_n = $signed({2'b00, exp_p1}) - $signed({{(ExpW-LzcW){1'b0}}, shamt});
    end
    mr    = round_rne(norm);
    exp_r = exp_n + $signed({{(ExpW-1){1'b0}}, mr[MrW-1]});
    // A rounding carry leaves M = 1.0, so the fraction is all zeros either way.
    frac  = mr[MrW-1] ? mr[MrW-2:1] : mr[MrW-3:0];
    res   = {sign_p1, exp_r[ExponentSize-1:0], frac};
    ovf   = 1'b0;
    unf   = 1'b0;
    if (is_zero) begin
      res = sub_p1 ? '0 : {sign_p1, {(DataSize-1){1'b0}}};
    end else if (exp_n <= 0) begin
      res = {sign_p1, {(DataSize-1){1'b0}}};
      unf = 1'b1;
    end else if (exp_r >= $signed(ExpW'(ExpMax))) begin
      res = {sign_p1, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
      ovf = 1'b1;
    end
  end

  // ---- PACK stage: bubbles pass through with flags forced low
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      ovf_p2    <= 1'b0;
      unf_p2    <= 1'b0;
    end else if (advance) begin
      vld_p2    <= vld_p1;
      result_p2 <= res;
      ovf_p2    <= vld_p1 & ovf;
      unf_p2    <= vld_p1 & unf;
    end
  end

endmodule

// File: tb/tb_fp_addsub_norm_round_stage.sv
// Directed bench for fp_addsub_norm_round_stage: vector table plus stall and reset sequences.
module tb_fp_addsub_norm_round_stage;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [26:0] Adder1;
  logic [26:0] Adder2;
  logic [7:0]  ExponentBase;
  logic        EffOperation;
  logic        ResultSign;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Overflow;
  logic        Underflow;

  int checks = 0;
  int errors = 0;

  fp_addsub_norm_round_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InValid      (InValid),
    .InReady      (InReady),
    .Adder1       (Adder1),
    .Adder2       (Adder2),
    .ExponentBase (ExponentBase),
    .EffOperation (EffOperation),
    .ResultSign   (ResultSign),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .Result       (Result),
    .Overflow     (Overflow),
    .Underflow    (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [26:0] a1;
    logic [26:0] a2;
    logic [7:0]  e;
    logic        eff;
    logic        sgn;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [26:0] a1, input logic [26:0] a2, input logic [7:0] e,
                       input logic eff, input logic sgn);
    Adder1       = a1;
    Adder2       = a2;
    ExponentBase = e;
    EffOperation = eff;
    ResultSign   = sgn;
    InValid      = 1'b1;
  endtask

  initial begin
    //           a1            a2            exp     eff   sgn   result         ovf   unf
    vecs[0]  = '{27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[1]  = '{27'h3FFFFFF, 27'h4000000, 8'd127, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{27'h4000004, 27'h0000000, 8'd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[3]  = '{27'h400000C, 27'h0000000, 8'd127, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0};
    vecs[4]  = '{27'h4000000, 27'h4000000, 8'd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[5]  = '{27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b1, 32'hC0000000, 1'b0, 1'b0};
    vecs[6]  = '{27'h4000000, 27'h5FFFFFF, 8'd127, 1'b1, 1'b0, 32'h3F000000, 1'b0, 1'b0};
    vecs[7]  = '{27'h4000000, 27'h5FFFFFF, 8'd1,   1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{27'h7FFFFFC, 27'h0000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[9]  = '{27'h4000006, 27'h0000000, 8'd127, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vecs[10] = '{27'h4000003, 27'h0000000, 8'd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[11] = '{27'h4000000, 27'h4000009, 8'd127, 1'b0, 1'b0, 32'h40000001, 1'b0, 1'b0};
    vecs[12] = '{27'h7FFFFFC, 27'h0000000, 8'd254, 1'b0, 1'b1, 32'hFF800000, 1'b1, 1'b0};
    vecs[13] = '{27'h4000000, 27'h0000000, 8'd254, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0};
    vecs[14] = '{27'h4000008, 27'h3FFFFFF, 8'd127, 1'b1, 1'b0, 32'h34000000, 1'b0, 1'b0};

    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    Adder1 = '0;
    Adder2 = '0;
    ExponentBase = '0;
    EffOperation = 1'b0;
    ResultSign = 1'b0;
    step();
    step();
    check("reset_outvalid", OutValid, 0);
    check("reset_result", Result, 0);
    check("reset_overflow", Overflow, 0);
    check("reset_underflow", Underflow, 0);
    check("reset_inready", InReady, 1);
    Reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a1, vecs[i].a2, vecs[i].e, vecs[i].eff, vecs[i].sgn);
      step();
      InValid = 1'b0;
      check($sformatf("vec%0d_latency_outvalid", i), OutValid, 0);
      check($sformatf("vec%0d_bubble_flags", i), {Overflow, Underflow}, 0);
      step();
      check($sformatf("vec%0d_outvalid", i), OutValid, 1);
      check($sformatf("vec%0d_result", i), Result, vecs[i].res);
      check($sformatf("vec%0d_overflow", i), Overflow, vecs[i].ovf);
      check($sformatf("vec%0d_underflow", i), Underflow, vecs[i].unf);
    end
    step();

    // Stall: three ops queued behind a consumer that holds OutReady low.
    OutReady = 1'b0;
    drive(27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b0);
    #1;
    check("stall_inready_a", InReady, 1);
    step();
    drive(27'h4000004, 27'h0000000, 8'd127, 1'b0, 1'b0);
    #1;
    check("stall_inready_b", InReady, 1);
    step();
    drive(27'h400000C, 27'h0000000, 8'd127, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_inready", k), InReady, 0);
      check($sformatf("stall%0d_outvalid", k), OutValid, 1);
      check($sformatf("stall%0d_result", k), Result, 32'h40000000);
      step();
    end
    OutReady = 1'b1;
    #1;
    check("stall_release_inready", InReady, 1);
    step();
    InValid = 1'b0;
    check("stall_out_b_valid", OutValid, 1);
    check("stall_out_b", Result, 32'h3F800000);
    step();
    check("stall_out_c_valid", OutValid, 1);
    check("stall_out_c", Result, 32'h3F800002);
    step();
    check("stall_drained", OutValid, 0);

    // Reset with two ops in flight.
    drive(27'h4000000, 27'h4000000, 8'd254, 1'b0, 1'b0);
    step();
    drive(27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b0);
    step();
    InValid = 1'b0;
    check("inflight_ovf_before_reset", Overflow, 1);
    Reset = 1'b1;
    step();
    check("rst_inflight_outvalid", OutValid, 0);
    check("rst_inflight_result", Result, 0);
    check("rst_inflight_overflow", Overflow, 0);
    Reset = 1'b0;
    step();
    check("rst_no_stale_1", OutValid, 0);
    step();
    check("rst_no_stale_2", OutValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
